cpu_run_ctl: RTL and testbench

Execution controller for the single-cycle RISC-V core. It sits between the bench or host and the `control_unit`/`datapath` pair. It generates the core's `run` enable and its active-high reset. It sequences free-run, single-step and stop, halts on `ebreak`, enforces an optional cycle budget and counts committed cycles.

---
 rtl/cpu_run_ctl_if.sv | 26 ++
 rtl/cpu_run_ctl.sv | 116 +++++++++++
 tb/tb_cpu_run_ctl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctl_if.sv
// Host-side control bundle for cpu_run_ctl: run/step/stop requests in,
// core enables, halt status and commit counter out.
interface cpu_run_ctl_if #(
    parameter int unsigned W = 32
);
    logic          start;
    logic          step;
    logic          stop;
    logic          clear;
    logic [31:0]   instr;
    logic          run;
    logic          cpu_rst;
    logic          halted;
    logic [1:0]    cause;
    logic [W-1:0]  cycle_cnt;

    modport master (
        output start, step, stop, clear, instr,
        input  run, cpu_rst, halted, cause, cycle_cnt
    );

    modport slave (
        input  start, step, stop, clear, instr,
        output run, cpu_rst, halted, cause, cycle_cnt
    );
endinterface

// File: rtl/cpu_run_ctl.sv
// Execution controller for the single-cycle core: free-run / single-step / stop
// sequencing, ebreak halt, per-segment cycle budget and committed-cycle counter.
module cpu_run_ctl #(
    parameter int unsigned W       = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input logic         clk,
    input logic         rst,
    cpu_run_ctl_if.slave bus
);
    localparam bit          TimeoutEn = (TIMEOUT != 0);
    localparam int unsigned SegW      = TimeoutEn ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SegW-1:0] SegLast = SegW'(TimeoutEn ? TIMEOUT - 1 : 0);

    localparam logic [1:0] CauseNone    = 2'b00;
    localparam logic [1:0] CauseEbreak  = 2'b01;
    localparam logic [1:0] CauseStop    = 2'b10;
    localparam logic [1:0] CauseTimeout = 2'b11;

    typedef enum logic [2:0] {StIdle, StReset, StRun, StStep, StHalted} state_e;

    state_e          state_q;
    logic            mode_step_q;
    logic [SegW-1:0] seg_q;
    logic [1:0]      cause_q;
    logic            halted_q;
    logic [W-1:0]    cnt_q;

    logic is_ebreak;
    logic run_en;
    logic timeout_hit;

    assign is_ebreak   = (bus.instr == 32'h0010_0073);
    // Mealy enable so an ebreak is never committed.
    assign run_en      = ((state_q == StRun) || (state_q == StStep)) && !is_ebreak;
    assign timeout_hit = TimeoutEn && run_en && (state_q == StRun) && (seg_q == SegLast);

    assign bus.run       = run_en;
    assign bus.cpu_rst   = (state_q == StIdle) || (state_q == StReset);
    assign bus.halted    = halted_q;
    assign bus.cause     = cause_q;
    assign bus.cycle_cnt = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            mode_step_q <= 1'b0;
            seg_q       <= '0;
            cause_q     <= CauseNone;
            halted_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (run_en && (cnt_q != '1)) cnt_q <= cnt_q + W'(1);
            if (run_en && (state_q == StRun)) seg_q <= seg_q + SegW'(1);

            case (state_q)
                StIdle: begin
                    if (bus.clear) cnt_q <= '0;
                    if (bus.start) begin
                        state_q     <= StReset;
                        mode_step_q <= 1'b0;
                    end else if (bus.step) begin
                        state_q     <= StReset;
                        mode_step_q <= 1'b1;
                    end
                end
                StReset: begin
                    seg_q   <= '0;
                    state_q <= mode_step_q ? StStep : StRun;
                end
                StRun: begin
                    if (is_ebreak) begin
                        state_q  <= StHalted;
                        halted_q <= 1'b1;
                        cause_q  <= CauseEbreak;
                    end else if (timeout_hit) begin
                        state_q  <= StHalted;
                        halted_q <= 1'b1;
                        cause_q  <= CauseTimeout;
                    end else if (bus.stop) begin
                        state_q  <= StHalted;
                        halted_q <= 1'b1;
                        cause_q  <= CauseStop;
                    end
                end
                StStep: begin
                    state_q  <= StHalted;
                    halted_q <= 1'b1;
                    cause_q  <= is_ebreak ? CauseEbreak : CauseStop;
                end
                StHalted: begin
                    if (bus.clear) cnt_q <= '0;
                    // After ebreak the PC must restart, so only a full reset resume is allowed.
                    if (cause_q == CauseEbreak) begin
                        if (bus.start) begin
                            state_q     <= StReset;
                            mode_step_q <= 1'b0;
                            halted_q    <= 1'b0;
                            cause_q     <= CauseNone;
                        end
                    end else if (bus.start) begin
                        state_q  <= StRun;
                        seg_q    <= '0;
                        halted_q <= 1'b0;
                        cause_q  <= CauseNone;
                    end else if (bus.step) begin
                        state_q  <= StStep;
                        halted_q <= 1'b0;
                        cause_q  <= CauseNone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_run_ctl.sv
// Randomized self-checking bench for cpu_run_ctl; expectations come from
// scenario-level arithmetic (commit counts, halt cause) rather than a state copy.
module tb_cpu_run_ctl;
    localparam int unsigned TO     = 8;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_run_ctl_if #(.W(32)) bus ();
    cpu_run_ctl_if #(.W(4))  bus2 ();

    cpu_run_ctl #(.W(32), .TIMEOUT(TO)) dut  (.clk(clk), .rst(rst), .bus(bus));
    cpu_run_ctl #(.W(4),  .TIMEOUT(0))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt;

    function automatic logic [31:0] rand_instr();
        logic [31:0] v;
        v = $urandom;
        if (v == EBREAK) v = v ^ 32'h1;
        return v;
    endfunction

    // Inputs change just after the falling edge; outputs are read 1 time unit later.
    task automatic drive(input logic s_start, input logic s_step, input logic s_stop,
                         input logic s_clear, input logic [31:0] s_instr);
        @(negedge clk);
        bus.start = s_start; bus.step = s_step; bus.stop = s_stop;
        bus.clear = s_clear; bus.instr = s_instr;
        #1;
    endtask

    task automatic drive2(input logic s_start, input logic s_stop);
        @(negedge clk);
        bus2.start = s_start; bus2.step = 1'b0; bus2.stop = s_stop;
        bus2.clear = 1'b0; bus2.instr = rand_instr();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 0; bus.step = 0; bus.stop = 0; bus.clear = 0; bus.instr = rand_instr();
        bus2.start = 0; bus2.step = 0; bus2.stop = 0; bus2.clear = 0; bus2.instr = rand_instr();
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (bus.run !== 1'b0) begin n_err++; $display("FAIL rst_run got=%b exp=0", bus.run); end
        n_cmp++; if (bus.cpu_rst !== 1'b1) begin n_err++; $display("FAIL rst_cpu_rst got=%b exp=1", bus.cpu_rst); end
        n_cmp++; if (bus.halted !== 1'b0) begin n_err++; $display("FAIL rst_halted got=%b exp=0", bus.halted); end
        n_cmp++; if (bus.cause !== 2'b00) begin n_err++; $display("FAIL rst_cause got=%b exp=00", bus.cause); end
        n_cmp++; if (bus.cycle_cnt !== 32'd0) begin n_err++; $display("FAIL rst_cnt got=%0d exp=0", bus.cycle_cnt); end
        @(negedge clk) rst = 1'b1;
        exp_cnt = 0;
    endtask

    // from_idle: start from IDLE (with RESET cycle), else resume from HALTED with cause 10.
    task automatic test_run_stop(input bit from_idle, input int n);
        int commits = 0;
        drive(1, 0, 0, 0, rand_instr());
        if (from_idle) begin
            drive(0, 0, 0, 0, rand_instr());
            n_cmp++; if (bus.cpu_rst !== 1'b1 || bus.run !== 1'b0) begin
                n_err++; $display("FAIL reset_cycle cpu_rst=%b run=%b exp 1/0", bus.cpu_rst, bus.run); end
        end
        for (int k = 0; k < n; k++) begin
            drive(0, 0, (k == n - 1), 0, rand_instr());
            if (bus.run) commits++;
            if (k == 0) begin
                n_cmp++; if (bus.cause !== 2'b00 || bus.cpu_rst !== 1'b0) begin
                    n_err++; $display("FAIL run_status cause=%b cpu_rst=%b exp 00/0", bus.cause, bus.cpu_rst); end
            end
        end
        drive(0, 0, 0, 0, rand_instr());
        exp_cnt += 32'(n);
        n_cmp++; if (commits != n) begin n_err++; $display("FAIL stop_commits got=%0d exp=%0d", commits, n); end
        n_cmp++; if (bus.halted !== 1'b1 || bus.cause !== 2'b10) begin
            n_err++; $display("FAIL stop_halt halted=%b cause=%b exp 1/10", bus.halted, bus.cause); end
        n_cmp++; if (bus.cycle_cnt !== exp_cnt) begin
            n_err++; $display("FAIL stop_cnt got=%0d exp=%0d", bus.cycle_cnt, exp_cnt); end
    endtask

    task automatic test_ebreak(input int m);
        int commits = 0;
        drive(1, 0, 0, 0, rand_instr());
        for (int k = 0; k < m; k++) begin
            drive(0, 0, 0, 0, rand_instr());
            if (bus.run) commits++;
        end
        drive(0, 0, 0, 0, EBREAK);
        n_cmp++; if (bus.run !== 1'b0) begin n_err++; $display("FAIL ebreak_run got=%b exp=0", bus.run); end
        drive(0, 0, 0, 0, EBREAK);
        exp_cnt += 32'(m);
        n_cmp++; if (commits != m) begin n_err++; $display("FAIL ebreak_commits got=%0d exp=%0d", commits, m); end
        n_cmp++; if (bus.halted !== 1'b1 || bus.cause !== 2'b01) begin
            n_err++; $display("FAIL ebreak_halt halted=%b cause=%b exp 1/01", bus.halted, bus.cause); end
        n_cmp++; if (bus.cycle_cnt !== exp_cnt) begin
            n_err++; $display("FAIL ebreak_cnt got=%0d exp=%0d", bus.cycle_cnt, exp_cnt); end
        // step must be ignored after an ebreak halt
        drive(0, 1, 0, 0, rand_instr());
        drive(0, 0, 0, 0, rand_instr());
        n_cmp++; if (bus.run !== 1'b0 || bus.halted !== 1'b1) begin
            n_err++; $display("FAIL ebreak_step_ignored run=%b halted=%b exp 0/1", bus.run, bus.halted); end
        drive(0, 0, 0, 0, rand_instr());
        n_cmp++; if (bus.cause !== 2'b01) begin n_err++; $display("FAIL ebreak_cause_hold got=%b exp=01", bus.cause); end
        drive(1, 0, 0, 0, rand_instr());
        drive(0, 0, 0, 0, rand_instr());
        n_cmp++; if (bus.cpu_rst !== 1'b1 || bus.cause !== 2'b00 || bus.halted !== 1'b0) begin
            n_err++; $display("FAIL ebreak_restart cpu_rst=%b cause=%b halted=%b exp 1/00/0",
                              bus.cpu_rst, bus.cause, bus.halted); end
        drive(0, 0, 1, 0, rand_instr());
        n_cmp++; if (bus.run !== 1'b1 || bus.cpu_rst !== 1'b0) begin
            n_err++; $display("FAIL restart_run run=%b cpu_rst=%b exp 1/0", bus.run, bus.cpu_rst); end
        drive(0, 0, 0, 0, rand_instr());
        exp_cnt += 1;
        n_cmp++; if (bus.cause !== 2'b10 || bus.cycle_cnt !== exp_cnt) begin
            n_err++; $display("FAIL restart_stop cause=%b cnt=%0d exp 10/%0d", bus.cause, bus.cycle_cnt, exp_cnt); end
    endtask

    task automatic test_step();
        int stray = 0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, rand_instr());
            drive(0, 0, (i == 1), 0, rand_instr());
            n_cmp++; if (bus.run !== 1'b1) begin n_err++; $display("FAIL step_run[%0d] got=%b exp=1", i, bus.run); end
            drive(0, 0, 0, 0, rand_instr());
            n_cmp++; if (bus.run !== 1'b0 || bus.halted !== 1'b1 || bus.cause !== 2'b10) begin
                n_err++; $display("FAIL step_halt[%0d] run=%b halted=%b cause=%b exp 0/1/10",
                                  i, bus.run, bus.halted, bus.cause); end
            repeat ($urandom_range(0, 3)) begin
                drive(0, 0, 0, 0, rand_instr());
                if (bus.run) stray++;
            end
        end
        exp_cnt += 3;
        n_cmp++; if (stray != 0) begin n_err++; $display("FAIL step_gap_run got=%0d exp=0", stray); end
        n_cmp++; if (bus.cycle_cnt !== exp_cnt) begin
            n_err++; $display("FAIL step_cnt got=%0d exp=%0d", bus.cycle_cnt, exp_cnt); end
    endtask

    task automatic test_timeout();
        drive(0, 0, 0, 1, rand_instr());
        drive(0, 0, 0, 0, rand_instr());
        exp_cnt = 0;
        n_cmp++; if (bus.cycle_cnt !== 32'd0) begin n_err++; $display("FAIL halted_clear got=%0d exp=0", bus.cycle_cnt); end
        for (int seg = 0; seg < 2; seg++) begin
            int commits = 0;
            drive(1, 0, 0, 0, rand_instr());
            for (int k = 0; k < 20; k++) begin
                drive(0, 0, 0, (seg == 1 && k == 3), rand_instr());
                if (bus.run) commits++;
                if (bus.halted) break;
            end
            exp_cnt += TO;
            n_cmp++; if (commits != TO) begin n_err++; $display("FAIL timeout_commits[%0d] got=%0d exp=%0d", seg, commits, TO); end
            n_cmp++; if (bus.halted !== 1'b1 || bus.cause !== 2'b11) begin
                n_err++; $display("FAIL timeout_cause[%0d] halted=%b cause=%b exp 1/11", seg, bus.halted, bus.cause); end
        end
        n_cmp++; if (bus.cycle_cnt !== exp_cnt) begin
            n_err++; $display("FAIL timeout_cnt got=%0d exp=%0d", bus.cycle_cnt, exp_cnt); end
        drive(0, 0, 0, 1, rand_instr());
        drive(0, 0, 0, 0, rand_instr());
        exp_cnt = 0;
        n_cmp++; if (bus.cycle_cnt !== exp_cnt) begin n_err++; $display("FAIL timeout_clear got=%0d exp=0", bus.cycle_cnt); end
    endtask

    task automatic test_stop_ebreak();
        drive(1, 0, 0, 0, rand_instr());
        drive(0, 0, 0, 0, rand_instr());
        n_cmp++; if (bus.run !== 1'b1) begin n_err++; $display("FAIL se_run got=%b exp=1", bus.run); end
        drive(0, 0, 1, 0, EBREAK);
        n_cmp++; if (bus.run !== 1'b0) begin n_err++; $display("FAIL se_nocommit got=%b exp=0", bus.run); end
        drive(0, 0, 0, 0, rand_instr());
        exp_cnt += 1;
        n_cmp++; if (bus.cause !== 2'b01 || bus.cycle_cnt !== exp_cnt) begin
            n_err++; $display("FAIL se_cause cause=%b cnt=%0d exp 01/%0d", bus.cause, bus.cycle_cnt, exp_cnt); end
        @(negedge clk); #2 rst = 1'b0; #2 rst = 1'b1;
        exp_cnt = 0;
        drive(1, 1, 0, 0, rand_instr());
        drive(0, 0, 0, 0, rand_instr());
        n_cmp++; if (bus.cpu_rst !== 1'b1) begin n_err++; $display("FAIL both_reset got=%b exp=1", bus.cpu_rst); end
        drive(0, 0, 0, 0, rand_instr());
        drive(0, 0, 0, 0, rand_instr());
        n_cmp++; if (bus.run !== 1'b1 || bus.halted !== 1'b0) begin
            n_err++; $display("FAIL both_mode_run run=%b halted=%b exp 1/0", bus.run, bus.halted); end
        drive(0, 0, 1, 0, rand_instr());
        drive(0, 0, 0, 0, rand_instr());
        exp_cnt = 3;
        n_cmp++; if (bus.cause !== 2'b10 || bus.cycle_cnt !== exp_cnt) begin
            n_err++; $display("FAIL both_stop cause=%b cnt=%0d exp 10/%0d", bus.cause, bus.cycle_cnt, exp_cnt); end
    endtask

    task automatic test_async_reset();
        drive(1, 0, 0, 0, rand_instr());
        drive(0, 0, 0, 0, rand_instr());
        n_cmp++; if (bus.run !== 1'b1) begin n_err++; $display("FAIL ar_pre_run got=%b exp=1", bus.run); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (bus.run !== 1'b0 || bus.cpu_rst !== 1'b1) begin
            n_err++; $display("FAIL ar_now run=%b cpu_rst=%b exp 0/1", bus.run, bus.cpu_rst); end
        n_cmp++; if (bus.cycle_cnt !== 32'd0 || bus.halted !== 1'b0 || bus.cause !== 2'b00) begin
            n_err++; $display("FAIL ar_state cnt=%0d halted=%b cause=%b exp 0/0/00",
                              bus.cycle_cnt, bus.halted, bus.cause); end
        @(negedge clk) rst = 1'b1;
        exp_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_instr());
            n_cmp++; if (bus.cpu_rst !== 1'b1 || bus.run !== 1'b0) begin
                n_err++; $display("FAIL ar_idle[%0d] cpu_rst=%b run=%b exp 1/0", k, bus.cpu_rst, bus.run); end
        end
        drive(0, 1, 0, 0, rand_instr());
        drive(0, 0, 0, 0, rand_instr());
        drive(0, 0, 0, 0, rand_instr());
        n_cmp++; if (bus.run !== 1'b1 || bus.cpu_rst !== 1'b0) begin
            n_err++; $display("FAIL idle_step_run run=%b cpu_rst=%b exp 1/0", bus.run, bus.cpu_rst); end
        drive(0, 0, 0, 0, rand_instr());
        exp_cnt += 1;
        n_cmp++; if (bus.halted !== 1'b1 || bus.cause !== 2'b10 || bus.cycle_cnt !== exp_cnt) begin
            n_err++; $display("FAIL idle_step_halt halted=%b cause=%b cnt=%0d exp 1/10/%0d",
                              bus.halted, bus.cause, bus.cycle_cnt, exp_cnt); end
    endtask

    // Narrow counter with the budget disabled: long run must saturate, never time out.
    task automatic test_saturate();
        int commits = 0;
        drive2(1, 0);
        drive2(0, 0);
        for (int k = 0; k < 20; k++) begin
            drive2(0, 0);
            if (bus2.run) commits++;
        end
        n_cmp++; if (commits != 20 || bus2.halted !== 1'b0) begin
            n_err++; $display("FAIL notimeout commits=%0d halted=%b exp 20/0", commits, bus2.halted); end
        n_cmp++; if (bus2.cycle_cnt !== 4'hF) begin n_err++; $display("FAIL saturate got=%0d exp=15", bus2.cycle_cnt); end
        drive2(0, 1);
        drive2(0, 0);
        n_cmp++; if (bus2.cause !== 2'b10 || bus2.cycle_cnt !== 4'hF) begin
            n_err++; $display("FAIL sat_stop cause=%b cnt=%0d exp 10/15", bus2.cause, bus2.cycle_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_run_stop(1'b1, 6);
        repeat (3) test_run_stop(1'b0, int'($urandom_range(1, TO - 1)));
        test_ebreak(int'($urandom_range(1, 6)));
        test_step();
        test_timeout();
        test_stop_ebreak();
        test_async_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
